// File: rtl/mem_axi_bridge_pkg.sv
// Shared types and response codes for the memory bridge.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mem_axi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_RESP = 2'd3
  } mem_axi_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mem_axi_bridge_bram_sp.sv
// Single-port synchronous BRAM model, write-first, no reset on contents.
// Latency: read data appears 1 cycle after en && !we; write commits at the en edge.
// Backpressure: none, accepts one access per cycle.
module bram_sp #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // One access per cycle; a write also returns the written word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_axi_bridge.sv
// AXI-lite-style slave driving one external single-port BRAM, one transaction at a time, reads win.
// Latency: read accept T -> rvalid at T+2; write accept T -> bvalid at T+1.
// Backpressure: all ready outputs low outside IDLE; responses held until rready/bready.
module mem_axi_bridge
  import mem_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 4096,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  mem_axi_state_t state;
  mem_axi_state_t next_state;

  logic rd_ok;        // range check of the read in flight
  logic ar_in_range;
  logic aw_in_range;
  logic rd_accept;
  logic wr_accept;

  // Byte offset within a word carries no meaning for this memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

  // Word address (byte address without the low two bits) below the BRAM depth.
  function automatic logic word_in_range(input logic [ADDR_WIDTH-3:0] word);
    return {2'b00, word} < ADDR_WIDTH'(MEM_WORDS);
  endfunction

  assign ar_in_range = word_in_range(araddr[ADDR_WIDTH-1:2]);
  assign aw_in_range = word_in_range(awaddr[ADDR_WIDTH-1:2]);

  // Ready registers are only high in IDLE, so they also gate acceptance right after reset.
  assign rd_accept = (state == IDLE) && arready && arvalid;
  assign wr_accept = (state == IDLE) && awready && wready && awvalid && wvalid && !arvalid;

  // Next-state: reads take precedence over a simultaneous complete write request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (rd_accept)      next_state = RD_WAIT;
        else if (wr_accept) next_state = WR_RESP;
      end
      RD_WAIT: next_state = RD_RESP;
      RD_RESP: if (rready) next_state = IDLE;
      WR_RESP: if (bready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register plus all registered channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      arready <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      rvalid  <= 1'b0;
      bvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      bresp   <= RESP_OKAY;
      rd_ok   <= 1'b0;
    end else begin
      state   <= next_state;
      arready <= (next_state == IDLE);
      awready <= (next_state == IDLE);
      wready  <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (rd_accept) begin
            rd_ok <= ar_in_range;
          end else if (wr_accept) begin
            bvalid <= 1'b1;
            bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RD_WAIT: begin
          rvalid <= 1'b1;
          rdata  <= rd_ok ? mem_rdata : '0;
          rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
        RD_RESP: if (rready) rvalid <= 1'b0;
        WR_RESP: if (bready) bvalid <= 1'b0;
        default: ;
      endcase
    end
  end

  // BRAM drive only in the accept cycle and only for in-range words.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (rd_accept) begin
        mem_addr = araddr[AW+1:2];
        mem_en   = ar_in_range;
      end else if (wr_accept) begin
        mem_addr  = awaddr[AW+1:2];
        mem_en    = aw_in_range;
        mem_we    = aw_in_range;
        mem_wdata = wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Self-checking bench: bridge plus BRAM model, vector table and corner-case sequences.
// Latency: read response expected 2 cycles after accept, write response 1 cycle.
// Backpressure: exercises held bready, read/write collision, held arvalid and mid-read reset.
module tb_mem_axi_bridge;
  import mem_axi_pkg::*;

  localparam int ADDR_WIDTH = 20;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_WORDS  = 4096;
  localparam int AW         = 12;

  logic                  clk;
  logic                  rst;
  logic                  arvalid, arready, rvalid, rready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  awvalid, awready, wvalid, wready, bvalid, bready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [1:0]            bresp;
  logic                  mem_en, mem_we;
  logic [AW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

  mem_axi_bridge #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  bram_sp #(.AW(AW), .DW(DATA_WIDTH)) u_bram (
    .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
    .wdata(mem_wdata), .rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks  = 0;
  int   errors  = 0;
  int   mem_cnt = 0;
  int   acc_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s", nm, what);
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return arready === 1'b1;
      1:       return (awready === 1'b1) && (wready === 1'b1);
      2:       return rvalid === 1'b1;
      default: return bvalid === 1'b1;
    endcase
  endfunction

  // Counts negedges until the selected condition holds; -1 on timeout.
  task automatic wait_for(input int sel, input string nm, output int cnt);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cond(sel)) begin
        cnt = i;
        return;
      end
    end
    fail(nm, "no event within 20 cycles, expected one");
    cnt = -1;
  endtask

  // Scoreboard and activity counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_en === 1'b1) mem_cnt++;
    if (arvalid && arready === 1'b1) acc_cnt++;
    if (rst === 1'b0 && rvalid === 1'b1 && rready) begin
      if (sb_q.size() == 0) fail("sb_rd", "unexpected read response, expected none");
      else begin
        sb_e = sb_q.pop_front();
        check("sb_rd_kind", 64'(sb_e.wr), 64'(0));
        check("sb_rdata", 64'(rdata), 64'(sb_e.data));
        check("sb_rresp", 64'(rresp), 64'(sb_e.resp));
      end
    end
    if (rst === 1'b0 && bvalid === 1'b1 && bready) begin
      if (sb_q.size() == 0) fail("sb_wr", "unexpected write response, expected none");
      else begin
        sb_e = sb_q.pop_front();
        check("sb_wr_kind", 64'(sb_e.wr), 64'(1));
        check("sb_bresp", 64'(bresp), 64'(sb_e.resp));
      end
    end
  end

  // One complete transaction with accept-cycle BRAM checks and latency check.
  task automatic xfer(input vec_t v, input string nm);
    int   c;
    int   m0;
    bit   inr;
    exp_t e;
    inr = (v.addr[19:2] < 18'd4096);
    m0  = mem_cnt;
    @(posedge clk); #1;
    if (v.wr) begin
      awvalid = 1'b1; awaddr = v.addr; wvalid = 1'b1; wdata = v.wdata;
    end else begin
      arvalid = 1'b1; araddr = v.addr;
    end
    wait_for(v.wr ? 1 : 0, {nm, "_accept"}, c);
    if (c > 0) begin
      e.wr = v.wr; e.data = v.exp_data; e.resp = v.exp_resp;
      sb_q.push_back(e);
      check({nm, "_mem_en"}, 64'(mem_en), 64'(inr));
      if (inr) begin
        check({nm, "_mem_we"}, 64'(mem_we), 64'(v.wr));
        check({nm, "_mem_addr"}, 64'(mem_addr), 64'(v.addr[13:2]));
        if (v.wr) check({nm, "_mem_wdata"}, 64'(mem_wdata), 64'(v.wdata));
      end
    end
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (c > 0) begin
      wait_for(v.wr ? 3 : 2, {nm, "_resp"}, c);
      if (c > 0) check({nm, "_latency"}, 64'(c), v.wr ? 64'(1) : 64'(2));
    end
    @(posedge clk);
    check({nm, "_mem_accesses"}, 64'(mem_cnt - m0), 64'(inr));
  endtask

  vec_t vecs[11];
  exp_t e;
  int   c;
  int   m0;
  int   a0;

  initial begin
    vecs[0]  = '{1'b1, 20'h00010, 32'hDEADBEEF, 32'h0,        RESP_OKAY};
    vecs[1]  = '{1'b0, 20'h00013, 32'h0,        32'hDEADBEEF, RESP_OKAY};
    vecs[2]  = '{1'b1, 20'h00000, 32'hA5A5A5A5, 32'h0,        RESP_OKAY};
    vecs[3]  = '{1'b1, 20'h04000, 32'h12345678, 32'h0,        RESP_SLVERR};
    vecs[4]  = '{1'b0, 20'h00000, 32'h0,        32'hA5A5A5A5, RESP_OKAY};
    vecs[5]  = '{1'b0, 20'h04000, 32'h0,        32'h0,        RESP_SLVERR};
    vecs[6]  = '{1'b1, 20'h03FFC, 32'hCAFEF00D, 32'h0,        RESP_OKAY};
    vecs[7]  = '{1'b0, 20'h03FFF, 32'h0,        32'hCAFEF00D, RESP_OKAY};
    vecs[8]  = '{1'b0, 20'hFFFFC, 32'h0,        32'h0,        RESP_SLVERR};
    vecs[9]  = '{1'b1, 20'h00011, 32'h11112222, 32'h0,        RESP_OKAY};
    vecs[10] = '{1'b0, 20'h00010, 32'h0,        32'h11112222, RESP_OKAY};

    rst = 1'b1;
    arvalid = 1'b0; araddr = '0; awvalid = 1'b0; awaddr = '0;
    wvalid = 1'b0; wdata = '0; rready = 1'b0; bready = 1'b0;

    // Reset with toggling inputs.
    repeat (2) begin
      @(posedge clk); #1;
      arvalid = 1'($urandom); awvalid = 1'($urandom); wvalid = 1'($urandom);
      araddr = 20'($urandom); awaddr = 20'($urandom); wdata = $urandom;
      rready = 1'($urandom); bready = 1'($urandom);
    end
    @(negedge clk);
    check("rst_outputs",
          64'({arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp, mem_en, mem_we}),
          64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_after", 64'({arready, awready, wready}), 64'(3'b111));

    // Table-driven transactions.
    for (int i = 0; i < 11; i++) xfer(vecs[i], $sformatf("vec%0d", i));

    // Write response held while bready is low.
    @(posedge clk); #1;
    bready = 1'b0;
    awvalid = 1'b1; awaddr = 20'h00020; wvalid = 1'b1; wdata = 32'h00000077;
    wait_for(1, "bhold_accept", c);
    e.wr = 1'b1; e.data = '0; e.resp = RESP_OKAY;
    sb_q.push_back(e);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_for(3, "bhold_resp", c);
    check("bhold_latency", 64'(c), 64'(1));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("bhold_bvalid%0d", i), 64'({bvalid, bresp}), 64'({1'b1, RESP_OKAY}));
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(negedge clk);
    check("bhold_final", 64'(bvalid), 64'(1));
    @(negedge clk);
    check("bhold_cleared", 64'(bvalid), 64'(0));
    xfer('{1'b0, 20'h00020, 32'h0, 32'h00000077, RESP_OKAY}, "bhold_rb");

    // Read wins a collision; write follows right after the read handshake.
    xfer('{1'b1, 20'h00008, 32'h0BAD0BAD, 32'h0, RESP_OKAY}, "col_pre");
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 20'h00008;
    awvalid = 1'b1; awaddr = 20'h00008; wvalid = 1'b1; wdata = 32'h00000055;
    wait_for(0, "col_ar", c);
    e.wr = 1'b0; e.data = 32'h0BAD0BAD; e.resp = RESP_OKAY;
    sb_q.push_back(e);
    check("col_read_first", 64'(mem_we), 64'(0));
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_for(2, "col_rvalid", c);
    check("col_rd_latency", 64'(c), 64'(2));
    @(negedge clk);
    e.wr = 1'b1; e.data = '0; e.resp = RESP_OKAY;
    sb_q.push_back(e);
    check("col_wr_accept", 64'({awready, wready, mem_en, mem_we, mem_addr}),
          64'({1'b1, 1'b1, 1'b1, 1'b1, 12'd2}));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_for(3, "col_bvalid", c);
    check("col_wr_latency", 64'(c), 64'(1));
    @(posedge clk);
    xfer('{1'b0, 20'h00008, 32'h0, 32'h00000055, RESP_OKAY}, "col_rb");

    // arvalid held 2 cycles past the handshake: exactly one extra read.
    m0 = mem_cnt;
    a0 = acc_cnt;
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 20'h00010;
    wait_for(0, "held_accept", c);
    e.wr = 1'b0; e.data = 32'h11112222; e.resp = RESP_OKAY;
    sb_q.push_back(e);
    wait_for(2, "held_rvalid", c);
    @(negedge clk);
    check("held_idle_ready", 64'(arready), 64'(1));
    sb_q.push_back(e);
    @(negedge clk);
    check("held_busy_ready", 64'(arready), 64'(0));
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_for(2, "held_rvalid2", c);
    check("held_rd2_timing", 64'(c), 64'(1));
    @(posedge clk);
    check("held_mem_accesses", 64'(mem_cnt - m0), 64'(2));
    check("held_accepts", 64'(acc_cnt - a0), 64'(2));

    // Reset while the BRAM read is returning drops the response.
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = 20'h00010;
    wait_for(0, "rstrd_accept", c);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstrd_wait_rvalid", 64'(rvalid), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstrd_rvalid%0d", i), 64'(rvalid), 64'(0));
    end
    xfer('{1'b0, 20'h00010, 32'h0, 32'h11112222, RESP_OKAY}, "rstrd_next");

    repeat (2) @(posedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

AXI-lite-style slave that terminates the core's memory channels (read: `arvalid/arready/araddr`, `rvalid/rready/rdata`; write: `awvalid/awaddr`, `wvalid/wdata`, `bvalid/bready/bresp`) and drives one single-port synchronous BRAM. It sits directly downstream of the RISC-V control unit and serves both instruction fetches and load/store traffic. It handles one transaction at a time, applies fixed read priority, and reports SLVERR for out-of-range addresses.

## Interface
- `ADDR_WIDTH`, 20: byte-address width of `araddr`/`awaddr`.
- `DATA_WIDTH`, 32: data width.
- `MEM_WORDS`, 4096: BRAM depth in words. Power of two. `AW = $clog2(MEM_WORDS)`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `arvalid` in 1, `arready` out 1, `araddr` in ADDR_WIDTH: read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out DATA_WIDTH, `rresp` out 2: read response channel.
- `awvalid` in 1, `awready` out 1, `awaddr` in ADDR_WIDTH: write address channel.
- `wvalid` in 1, `wready` out 1, `wdata` in DATA_WIDTH: write data channel.
- `bvalid` out 1, `bready` in 1, `bresp` out 2: write response channel.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out DATA_WIDTH: BRAM request port.
- `mem_rdata` in DATA_WIDTH: BRAM read data, valid exactly 1 cycle after `mem_en && !mem_we`.

## Operation
- States:
  - IDLE: `arready`, `awready` and `wready` are 1.
  - RD_WAIT: BRAM data is returning.
  - RD_RESP: `rvalid` is held.
  - WR_RESP: `bvalid` is held.
- Address mapping:
  - Word index is `addr[AW+1:2]`; `addr[1:0]` is ignored.
  - In range means `addr[ADDR_WIDTH-1:2] < MEM_WORDS`.
- Read accept: in IDLE, `arvalid && arready`.
  - Latch the range check and go to RD_WAIT.
  - If in range, drive `mem_en=1`, `mem_we=0` and `mem_addr` combinationally in the same cycle.
- RD_WAIT: register `rdata` and `rresp`, set `rvalid=1`, go to RD_RESP.
  - In range: `rdata=mem_rdata`, `rresp=2'b00`.
  - Out of range: `rdata=0`, `rresp=2'b10`.
- RD_RESP: hold `rvalid`, `rdata` and `rresp` stable until `rready`. On `rvalid && rready`, clear `rvalid` and return to IDLE.
- Write accept: in IDLE, `awvalid && wvalid` with no `arvalid`.
  - If in range, drive `mem_en=1`, `mem_we=1`, `mem_addr` and `mem_wdata=wdata` combinationally.
  - Go to WR_RESP with `bvalid=1` and `bresp` = 00 (in range) or 10 (out of range).
  - `awvalid` without `wvalid`, or the reverse, is not accepted; it waits in IDLE.
- WR_RESP: hold `bvalid` and `bresp` until `bready`, then return to IDLE.
- Read priority: `arvalid` together with `awvalid && wvalid` in IDLE serves the read. The write is accepted on the first IDLE cycle after the read completes.
- Outside IDLE, `arready`, `awready` and `wready` are 0. A master holding `arvalid`/`awvalid` high after its handshake is ignored until IDLE.
- `mem_en` is never asserted for an out-of-range access, or outside IDLE.

## Timing
- Reset values:
  - Outputs 0: `arready`, `awready`, `wready`, `rvalid`, `bvalid`, `rdata`, `rresp`, `bresp`, `mem_en`, `mem_we`.
  - State is IDLE.
- The ready outputs are registered. They are 1 from the first cycle after `rst` deasserts, and are driven 0 on the entry cycle of any non-IDLE state.
- Read latency: accept at cycle T, BRAM sampled at the T edge, `rvalid=1` at T+2. Minimum read occupancy is 3 cycles including the IDLE return.
- Write latency: accept at T, BRAM written at the T edge, `bvalid=1` at T+1.
- Back-to-back: a new accept is possible in the cycle after the response handshake.
- `rst` mid-transaction: the pending response is dropped, `rvalid`/`bvalid` are 0 the next cycle, and the state is IDLE. A BRAM write already committed stays committed.

## Structure
- Shared package `mem_axi_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_RESP} mem_axi_state_t`.
  - Constants `RESP_OKAY=2'b00` and `RESP_SLVERR=2'b10`.
- The BRAM is external. Sub-module `bram_sp` (single-port, 1-cycle sync read, write-first) is the bench and top-level memory model; it is not instantiated inside the bridge.
- One `always_ff` block holds the state and registered outputs. One `always_comb` block produces the `mem_*` drive.

## Test plan
- Reset: hold `rst` 2 cycles with all inputs toggling.
  - All outputs are 0 during reset.
  - `arready=awready=wready=1` the cycle after release.
- Write then read:
  - Write `awaddr=0x00010`, `wdata=0xDEADBEEF` -> `mem_we=1` and `mem_addr=4` in the accept cycle, `bvalid=1` with `bresp=00` at T+1.
  - Hold `bready=0` for 3 cycles -> `bvalid` stays high.
  - Read `araddr=0x00013` -> `rvalid` at T+2 with `rdata=0xDEADBEEF`, `rresp=00`.
- Out of range (`MEM_WORDS=4096`), access at `0x04000`:
  - Read -> `mem_en` never asserted, `rvalid` at T+2 with `rdata=0`, `rresp=10`.
  - Write -> `mem_en` never asserted, `bresp=10`; BRAM contents unchanged.
- Collision: in IDLE, `arvalid=1` together with `awvalid=wvalid=1` (`awaddr=0x8`, `wdata=0x55`).
  - The read completes first.
  - The write is accepted in the cycle after `rvalid && rready`.
  - A subsequent read of `0x8` returns `0x55`.
- Held valid: the master keeps `arvalid=1` for 2 cycles after `rvalid && rready` -> exactly one extra read is accepted, on the first IDLE cycle, and no BRAM access occurs outside IDLE.
- Reset mid-read: assert `rst` in RD_WAIT -> `rvalid` never asserts, and the next read after release completes with correct data.
